// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the SRAM-like request arbiter: transfer size codes,
// arbiter state encoding and an index-width helper.
package mem_req_arbiter_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } arb_state_e;

   // Bits needed to name one of n items; never less than one.
   function automatic int idx_w(input int n);
      if (n > 1) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/mem_req_arbiter_owner_fifo.sv
// Owner FIFO: remembers which requester issued each accepted transaction so
// in-order responses can be routed back.
module owner_fifo
   import mem_req_arbiter_pkg::*;
#(
   parameter int W     = 2,
   parameter int DEPTH = 4
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_push,
   input  logic [W-1:0] i_push_data,
   input  logic         i_pop,
   output logic         o_full,
   output logic         o_empty,
   output logic [W-1:0] o_head
);

   localparam int AW = idx_w(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   // Qualify requests so over/underflow can never corrupt the pointers.
   always_comb begin
      w_push  = i_push && !o_full;
      w_pop   = i_pop && !o_empty;
      o_full  = (r_count == (AW+1)'(DEPTH));
      o_empty = (r_count == '0);
      o_head  = r_mem[r_head];
   end

   // Pointer and occupancy registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_tail <= r_tail + AW'(1);
         end
         if (w_pop) begin
            r_head <= r_head + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage; contents are meaningless while the FIFO is empty, so no reset.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_tail] <= i_push_data;
      end
   end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one SRAM-like master port among NREQ requesters;
// grants lock until the address is accepted and responses follow the owner FIFO.
module mem_req_arbiter
   import mem_req_arbiter_pkg::*;
#(
   parameter int NREQ    = 3,
   parameter int MAX_OUT = 4
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [NREQ-1:0]      i_req,
   input  logic [NREQ-1:0]      i_wr,
   input  logic [2*NREQ-1:0]    i_size,
   input  logic [32*NREQ-1:0]   i_addr,
   input  logic [32*NREQ-1:0]   i_wdata,
   output logic [NREQ-1:0]      o_addr_ok,
   output logic [NREQ-1:0]      o_data_ok,
   output logic [31:0]          o_rdata,
   output logic                 o_m_req,
   output logic                 o_m_wr,
   output logic [1:0]           o_m_size,
   output logic [31:0]          o_m_addr,
   output logic [31:0]          o_m_wdata,
   input  logic                 i_m_addr_ok,
   input  logic                 i_m_data_ok,
   input  logic [31:0]          i_m_rdata,
   output logic                 o_stray_err
);

   localparam int IW = idx_w(NREQ);

   arb_state_e    r_state;
   arb_state_e    w_state_nxt;
   logic [IW-1:0] r_own;
   logic [IW-1:0] w_own_nxt;
   logic [IW-1:0] r_rr;
   logic [IW-1:0] w_rr_nxt;
   logic [IW-1:0] w_winner;
   logic [IW-1:0] w_off;
   logic [IW:0]   w_sum;
   logic [NREQ-1:0] w_rot;
   logic [IW-1:0] w_sel;
   logic [IW-1:0] w_head;
   logic          w_any;
   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic          w_m_req;
   logic          r_stray;

   function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
      if (idx == IW'(NREQ - 1)) begin
         return '0;
      end else begin
         return idx + IW'(1);
      end
   endfunction

   // Round-robin scan: rotate so rr sits at bit 0, take the lowest set bit,
   // then rotate the offset back modulo NREQ.
   always_comb begin
      w_rot = NREQ'({i_req, i_req} >> r_rr);
      w_any = |i_req;
      w_off = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         w_off = w_rot[i] ? IW'(i) : w_off;
      end
      w_sum    = {1'b0, r_rr} + {1'b0, w_off};
      w_winner = (w_sum >= (IW+1)'(NREQ)) ? (w_sum[IW-1:0] - IW'(NREQ)) : w_sum[IW-1:0];
   end

   // Next-state and master request; LOCK keeps the owner on the bus even if
   // its request input drops.
   always_comb begin
      w_state_nxt = r_state;
      w_own_nxt   = r_own;
      w_rr_nxt    = r_rr;
      w_sel       = r_own;
      w_m_req     = 1'b0;
      w_push      = 1'b0;
      if (i_reset) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_sel = w_winner;
               if (w_any && !w_full) begin
                  w_m_req = 1'b1;
                  if (i_m_addr_ok) begin
                     w_push   = 1'b1;
                     w_rr_nxt = next_idx(w_winner);
                  end else begin
                     w_own_nxt   = w_winner;
                     w_state_nxt = ST_LOCK;
                  end
               end else begin
                  w_m_req = 1'b0;
               end
            end
            ST_LOCK: begin
               w_m_req = 1'b1;
               if (i_m_addr_ok) begin
                  w_push      = 1'b1;
                  w_rr_nxt    = next_idx(r_own);
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_LOCK;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // Master-side mux and per-requester handshake decode.
   always_comb begin
      o_m_req   = w_m_req;
      o_m_wr    = 1'b0;
      o_m_size  = 2'b00;
      o_m_addr  = 32'h0000_0000;
      o_m_wdata = 32'h0000_0000;
      o_rdata   = i_m_rdata;
      w_pop     = i_m_data_ok && !w_empty && !i_reset;
      for (int i = 0; i < NREQ; i++) begin
         o_m_wr       = (w_sel == IW'(i)) ? i_wr[i]            : o_m_wr;
         o_m_size     = (w_sel == IW'(i)) ? i_size[2*i +: 2]   : o_m_size;
         o_m_addr     = (w_sel == IW'(i)) ? i_addr[32*i +: 32] : o_m_addr;
         o_m_wdata    = (w_sel == IW'(i)) ? i_wdata[32*i +: 32] : o_m_wdata;
         o_addr_ok[i] = w_m_req && i_m_addr_ok && (w_sel == IW'(i));
         o_data_ok[i] = w_pop && (w_head == IW'(i));
      end
      o_stray_err = r_stray;
   end

   // Arbiter state, owner and round-robin pointer.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_own   <= '0;
         r_rr    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_own   <= w_own_nxt;
         r_rr    <= w_rr_nxt;
      end
   end

   // A response with nothing outstanding means bridge and arbiter disagree.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_stray <= 1'b0;
      end else if (i_m_data_ok && w_empty) begin
         r_stray <= 1'b1;
      end else begin
         r_stray <= r_stray;
      end
   end

   owner_fifo #(
      .W     (IW),
      .DEPTH (MAX_OUT)
   ) u_owner_fifo (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_push      (w_push),
      .i_push_data (w_sel),
      .i_pop       (w_pop),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_head      (w_head)
   );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: random requesters and a random slave,
// checked against a rule-level arbitration model and an owner queue.
module tb_mem_req_arbiter;

   localparam int NREQ    = 3;
   localparam int MAX_OUT = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [NREQ-1:0]    req = '0;
   logic [NREQ-1:0]    wr = '0;
   logic [2*NREQ-1:0]  size = '0;
   logic [32*NREQ-1:0] addr = '0;
   logic [32*NREQ-1:0] wdata = '0;
   logic [NREQ-1:0]    addr_ok;
   logic [NREQ-1:0]    data_ok;
   logic [31:0]        rdata;
   logic               m_req;
   logic               m_wr;
   logic [1:0]         m_size;
   logic [31:0]        m_addr;
   logic [31:0]        m_wdata;
   logic               m_addr_ok = 1'b0;
   logic               m_data_ok = 1'b0;
   logic [31:0]        m_rdata = 32'h0;
   logic               stray_err;

   always #5 clk = ~clk;

   mem_req_arbiter #(.NREQ(NREQ), .MAX_OUT(MAX_OUT)) dut (
      .i_clk(clk), .i_reset(reset), .i_req(req), .i_wr(wr), .i_size(size),
      .i_addr(addr), .i_wdata(wdata), .o_addr_ok(addr_ok), .o_data_ok(data_ok),
      .o_rdata(rdata), .o_m_req(m_req), .o_m_wr(m_wr), .o_m_size(m_size),
      .o_m_addr(m_addr), .o_m_wdata(m_wdata), .i_m_addr_ok(m_addr_ok),
      .i_m_data_ok(m_data_ok), .i_m_rdata(m_rdata), .o_stray_err(stray_err)
   );

   int checks = 0;
   int failures = 0;

   logic [31:0] rq_addr  [NREQ];
   logic [31:0] rq_wdata [NREQ];
   logic        rq_wr    [NREQ];
   logic [1:0]  rq_size  [NREQ];

   int  sb_q[$];
   int  mdl_rr, mdl_own, slave_pending;
   bit  mdl_lock, mdl_stray, popped_now, run_en;
   bit  acc_flag [NREQ];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [NREQ-1:0] onehot(input int k);
      logic [NREQ-1:0] v;
      v = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   task automatic drive_bus();
      for (int i = 0; i < NREQ; i++) begin
         addr[32*i +: 32]  = rq_addr[i];
         wdata[32*i +: 32] = rq_wdata[i];
         wr[i]             = rq_wr[i];
         size[2*i +: 2]    = rq_size[i];
      end
   endtask

   task automatic clear_model();
      sb_q.delete();
      mdl_rr = 0; mdl_own = 0; mdl_lock = 0; mdl_stray = 0; slave_pending = 0;
      for (int i = 0; i < NREQ; i++) acc_flag[i] = 0;
   endtask

   // Response monitor: each m_data_ok pops the oldest accepted owner.
   always @(negedge clk) begin
      popped_now = 0;
      if (run_en) begin
         chk("stray_err", {31'd0, stray_err}, {31'd0, mdl_stray});
         if (m_data_ok) begin
            if (sb_q.size() > 0) begin
               int owner;
               owner = sb_q.pop_front();
               popped_now = 1;
               chk("data_ok", {29'd0, data_ok}, {29'd0, onehot(owner)});
               chk("rdata", rdata, m_rdata);
            end else begin
               chk("data_ok_stray", {29'd0, data_ok}, 32'd0);
               mdl_stray = 1;
            end
         end else begin
            chk("data_ok_quiet", {29'd0, data_ok}, 32'd0);
         end
      end
   end

   // Arbitration model: a pending-but-unaccepted grant sticks; otherwise the
   // first requester at or after rr wins, provided fewer than MAX_OUT are open.
   always @(negedge clk) begin
      #1;
      if (run_en) begin
         int cnt, sel;
         bit exp_req;
         cnt = sb_q.size() + (popped_now ? 1 : 0);
         exp_req = 0;
         sel = 0;
         if (mdl_lock) begin
            exp_req = 1;
            sel = mdl_own;
         end else if (cnt < MAX_OUT) begin
            for (int k = 0; k < NREQ; k++) begin
               int j;
               j = (mdl_rr + k) % NREQ;
               if (req[j] && !exp_req) begin
                  exp_req = 1;
                  sel = j;
               end
            end
         end
         chk("m_req", {31'd0, m_req}, {31'd0, exp_req});
         if (exp_req) begin
            chk("m_addr", m_addr, rq_addr[sel]);
            chk("m_wdata", m_wdata, rq_wdata[sel]);
            chk("m_wr_size", {29'd0, m_wr, m_size}, {29'd0, rq_wr[sel], rq_size[sel]});
         end
         chk("addr_ok", {29'd0, addr_ok}, (exp_req && m_addr_ok) ? {29'd0, onehot(sel)} : 32'd0);
         if (exp_req && m_addr_ok) begin
            sb_q.push_back(sel);
            mdl_rr = (sel + 1) % NREQ;
            mdl_lock = 0;
            acc_flag[sel] = 1;
            slave_pending++;
         end else if (exp_req) begin
            mdl_lock = 1;
            mdl_own = sel;
         end
      end
   end

   task automatic do_reset();
      run_en = 0;
      @(posedge clk); #1;
      reset = 1; req = '1; m_addr_ok = 1; m_data_ok = 1;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         chk("rst_m_req", {31'd0, m_req}, 32'd0);
         chk("rst_addr_ok", {29'd0, addr_ok}, 32'd0);
         chk("rst_data_ok", {29'd0, data_ok}, 32'd0);
         chk("rst_stray", {31'd0, stray_err}, 32'd0);
      end
      @(posedge clk); #1;
      reset = 0; req = '0; m_addr_ok = 0; m_data_ok = 0;
      clear_model();
      run_en = 1;
   endtask

   task automatic step(input int p_req, input int p_aok, input int p_dok);
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
         if (acc_flag[i]) begin
            acc_flag[i] = 0;
            req[i] = 1'b0;
         end
         if (!req[i] && ($urandom_range(99) < p_req)) begin
            req[i]      = 1'b1;
            rq_addr[i]  = $urandom;
            rq_wdata[i] = $urandom;
            rq_wr[i]    = 1'($urandom_range(1));
            rq_size[i]  = 2'($urandom_range(2));
         end
      end
      m_addr_ok = ($urandom_range(99) < p_aok);
      m_rdata = $urandom;
      if (slave_pending > 0 && ($urandom_range(99) < p_dok)) begin
         m_data_ok = 1'b1;
         slave_pending--;
      end else begin
         m_data_ok = 1'b0;
      end
      drive_bus();
   endtask

   logic [NREQ-1:0] exp_ord [4];

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         rq_addr[i] = 32'h100 * i; rq_wdata[i] = 32'h0; rq_wr[i] = 0; rq_size[i] = 2'd2;
      end
      drive_bus();
      clear_model();
      run_en = 0;
      do_reset();

      // Single read from requester 1, answered two cycles after acceptance.
      rq_addr[1] = 32'h0000_1000; rq_wr[1] = 0; drive_bus();
      req = 3'b010; m_addr_ok = 1;
      @(negedge clk); #2;
      chk("single_addr_ok", {29'd0, addr_ok}, 32'd2);
      @(posedge clk); #1;
      req = '0; m_addr_ok = 0; acc_flag[1] = 0;
      @(posedge clk); #1;
      m_data_ok = 1; m_rdata = 32'hDEADBEEF; slave_pending--;
      @(negedge clk); #2;
      chk("single_data_ok", {29'd0, data_ok}, 32'd2);
      chk("single_rdata", rdata, 32'hDEADBEEF);
      @(posedge clk); #1;
      m_data_ok = 0;

      // Stray response with nothing outstanding; sticky until reset.
      @(posedge clk); #1;
      m_data_ok = 1;
      @(negedge clk); #2;
      chk("stray_no_data_ok", {29'd0, data_ok}, 32'd0);
      @(posedge clk); #1;
      m_data_ok = 0;
      repeat (3) begin
         @(negedge clk); #2;
         chk("stray_sticky", {31'd0, stray_err}, 32'd1);
         @(posedge clk); #1;
      end
      do_reset();
      @(negedge clk); #2;
      chk("stray_cleared", {31'd0, stray_err}, 32'd0);

      // All requesting, slave always ready: 0,1,2,0 then FIFO full.
      exp_ord[0] = 3'b001; exp_ord[1] = 3'b010; exp_ord[2] = 3'b100; exp_ord[3] = 3'b001;
      @(posedge clk); #1;
      req = '1; m_addr_ok = 1; m_data_ok = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); #2;
         chk("rr_order", {29'd0, addr_ok}, {29'd0, exp_ord[c]});
         @(posedge clk); #1;
      end
      @(negedge clk); #2;
      chk("full_block", {31'd0, m_req}, 32'd0);
      @(posedge clk); #1;
      m_data_ok = 1; m_rdata = 32'h1234_5678; slave_pending--;
      @(negedge clk); #2;
      chk("full_pop_owner", {29'd0, data_ok}, 32'd1);
      chk("full_pop_mreq", {31'd0, m_req}, 32'd0);
      @(posedge clk); #1;
      m_data_ok = 0;
      @(negedge clk); #2;
      chk("full_reassert", {31'd0, m_req}, 32'd1);
      chk("full_next_grant", {29'd0, addr_ok}, 32'd2);

      // Random traffic: moderate, FIFO-filling, and push/pop-heavy mixes.
      repeat (1500) step(40, 50, 50);
      repeat (800)  step(80, 80, 10);
      repeat (800)  step(90, 90, 90);
      repeat (100)  step(0, 100, 100);
      @(posedge clk); #1;
      m_data_ok = 0; m_addr_ok = 0; req = '0;
      @(negedge clk); #2;
      chk("drained_queue", sb_q.size(), 32'd0);
      chk("drained_slave", slave_pending, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
